// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus arbiter.
//   ADDR_*      : SPART ioaddr register map
//   arb_state_e : arbiter transaction state
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;  // TX/RX buffer
    localparam logic [1:0] ADDR_STAT = 2'b01;  // status
    localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low
    localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StIssue,
        StDone
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_valid_i  : per-requester request vector
//   last_grant_i : index granted most recently; search starts one above it, with wrap
//   grant_o      : one-hot grant (all zero when nothing requests)
//   grant_idx_o  : index of the granted requester
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]                                req_valid_i,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]     last_grant_i,
    output logic [NREQ-1:0]                                grant_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]     grant_idx_o
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic found;

    // Walk priority distance k = 1..NREQ from the last grant; the first hit wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid_i[i] && (((32'(last_grant_i) + k) % NREQ) == i)) begin
                    found       = 1'b1;
                    grant_o[i]  = 1'b1;
                    grant_idx_o = IdxW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter that owns the SPART processor bus on behalf of NREQ requesters.
// Each granted transaction makes exactly one single-cycle bus access (or times out).
//   clk, rst                 : clock, asynchronous active-low reset
//   req_valid_i/rw_i/addr_i/wdata_i : per-requester request, held until its ack
//   ack_o, err_o, rdata_o    : completion pulse (one-hot), timeout flag, last read data
//   busy_o                   : transaction in flight
//   iocs_o/iorw_o/ioaddr_o/databus_io, rda_i/tbr_i : SPART bus
module spart_bus_arbiter
    import spart_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid_i,
    input  logic [NREQ-1:0]     req_rw_i,
    input  logic [2*NREQ-1:0]   req_addr_i,
    input  logic [8*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]     ack_o,
    output logic                err_o,
    output logic [7:0]          rdata_o,
    output logic                busy_o,
    output logic                iocs_o,
    output logic                iorw_o,
    output logic [1:0]          ioaddr_o,
    input  logic                rda_i,
    input  logic                tbr_i,
    inout  wire  [7:0]          databus_io
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_oh_q, grant_oh_d;
    logic [IdxW-1:0] last_grant_q, last_grant_d;
    logic            rw_q, rw_d;
    logic [1:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;

    logic [NREQ-1:0] arb_grant;
    logic [IdxW-1:0] arb_idx;
    logic            sel_rw;
    logic [1:0]      sel_addr;
    logic [7:0]      sel_wdata;
    logic            wait_go;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_valid_i  (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx)
    );

    // Mux out the winning requester's fields for capture at grant.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_idx == IdxW'(i)) begin
                sel_rw    = req_rw_i[i];
                sel_addr  = req_addr_i[2*i +: 2];
                sel_wdata = req_wdata_i[8*i +: 8];
            end
        end
    end

    // Only buffer accesses are gated by SPART flow control.
    assign wait_go = (addr_q != ADDR_BUF) || (rw_q ? rda_i : tbr_i);

    always_comb begin
        state_d      = state_q;
        grant_oh_d   = grant_oh_q;
        last_grant_d = last_grant_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid_i) begin
                    grant_oh_d   = arb_grant;
                    last_grant_d = arb_idx;
                    rw_d         = sel_rw;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    wait_cnt_d   = '0;
                    err_d        = 1'b0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (wait_go) begin
                    state_d = StIssue;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == 16'(TIMEOUT - 1))) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StIssue: begin
                if (rw_q) begin
                    rdata_d = databus_io;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_oh_q   <= '0;
            last_grant_q <= IdxW'(NREQ - 1);
            rw_q         <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_oh_q   <= grant_oh_d;
            last_grant_q <= last_grant_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them asynchronously.
    assign iocs_o     = (state_q == StIssue);
    assign iorw_o     = (state_q == StIssue) ? rw_q : 1'b1;
    assign ioaddr_o   = addr_q;
    assign databus_io = ((state_q == StIssue) && !rw_q) ? wdata_q : 8'hzz;
    assign ack_o      = (state_q == StDone) ? grant_oh_q : '0;
    assign err_o      = (state_q == StDone) && err_q;
    assign busy_o     = (state_q != StIdle);
    assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed self-checking bench for spart_bus_arbiter.
// dut uses the default timeout; dut2 (TIMEOUT=8) covers the timeout path.
module tb_spart_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic        rda;
    logic        tbr;
    wire  [7:0]  databus;

    // SPART model: drives read data while selected for a read; the probe drives 00 to
    // expose any DUT drive in cycles where the bus must be released.
    logic        tb_probe_en;
    logic [7:0]  spart_rdata;
    logic        tb_en;
    logic [7:0]  tb_val;

    always_comb begin
        tb_en  = tb_probe_en | (iocs & iorw);
        tb_val = tb_probe_en ? 8'h00 : spart_rdata;
    end
    assign databus = tb_en ? tb_val : 8'hzz;

    logic [1:0]  req_valid2;
    logic [1:0]  ack2;
    logic        err2;
    logic [7:0]  rdata2;
    logic        busy2;
    logic        iocs2;
    logic        iorw2;
    logic [1:0]  ioaddr2;
    logic        rda2;
    wire  [7:0]  databus2;
    logic [7:0]  spart_rdata2;

    assign databus2 = (iocs2 && iorw2) ? spart_rdata2 : 8'hzz;

    int errors = 0;
    int checks = 0;

    spart_bus_arbiter #(
        .NREQ    (2),
        .TIMEOUT (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_rw_i    (req_rw),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .ack_o       (ack),
        .err_o       (err),
        .rdata_o     (rdata),
        .busy_o      (busy),
        .iocs_o      (iocs),
        .iorw_o      (iorw),
        .ioaddr_o    (ioaddr),
        .rda_i       (rda),
        .tbr_i       (tbr),
        .databus_io  (databus)
    );

    spart_bus_arbiter #(
        .NREQ    (2),
        .TIMEOUT (8)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid2),
        .req_rw_i    (req_rw),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .ack_o       (ack2),
        .err_o       (err2),
        .rdata_o     (rdata2),
        .busy_o      (busy2),
        .iocs_o      (iocs2),
        .iorw_o      (iorw2),
        .ioaddr_o    (ioaddr2),
        .rda_i       (rda2),
        .tbr_i       (tbr),
        .databus_io  (databus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL reset_iocs: got %b want 0", iocs); end
        checks++; if (iorw !== 1'b1) begin errors++; $display("FAIL reset_iorw: got %b want 1", iorw); end
        checks++; if (ioaddr !== 2'b00) begin errors++; $display("FAIL reset_ioaddr: got %b want 00", ioaddr); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_idle_ack: got %b want 00", ack); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_ack;
        logic [1:0] exp_addr;
        logic [7:0] exp_data;
        req_rw    = 2'b00;
        req_addr  = {2'b11, 2'b10};
        req_wdata = {8'h22, 8'h11};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 2'b10 : 2'b11;
            exp_data = (k % 2 == 0) ? 8'h11 : 8'h22;
            tick();
            checks++; if (busy !== 1'b1 || iocs !== 1'b0) begin errors++; $display("FAIL rr_wait[%0d]: got busy=%b iocs=%b want 1 0", k, busy, iocs); end
            tick();
            checks++; if (iocs !== 1'b1 || ioaddr !== exp_addr || databus !== exp_data) begin
                errors++; $display("FAIL rr_issue[%0d]: got iocs=%b addr=%b data=%h want 1 %b %h", k, iocs, ioaddr, databus, exp_addr, exp_data);
            end
            tick();
            checks++; if (ack !== exp_ack || err !== 1'b0) begin errors++; $display("FAIL rr_ack[%0d]: got ack=%b err=%b want %b 0", k, ack, err, exp_ack); end
            if (k == 3) req_valid = 2'b00;
            tick();
            checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rr_idle[%0d]: got ack=%b want 00", k, ack); end
        end
    endtask

    task automatic test_divisor_write;
        tb_probe_en = 1'b1;
        req_rw      = 2'b00;
        req_addr    = {2'b00, 2'b10};
        req_wdata   = {8'h00, 8'h45};
        req_valid   = 2'b01;
        #1;
        checks++; if (databus !== 8'h00) begin errors++; $display("FAIL div_idle_bus: got %h want 00", databus); end
        tick();
        checks++; if (databus !== 8'h00 || iocs !== 1'b0) begin errors++; $display("FAIL div_wait: got bus=%h iocs=%b want 00 0", databus, iocs); end
        tb_probe_en = 1'b0;
        tick();
        checks++; if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b10 || databus !== 8'h45) begin
            errors++; $display("FAIL div_issue: got iocs=%b iorw=%b addr=%b bus=%h want 1 0 10 45", iocs, iorw, ioaddr, databus);
        end
        tick();
        tb_probe_en = 1'b1;
        #1;
        checks++; if (ack !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL div_ack: got ack=%b err=%b want 01 0", ack, err); end
        checks++; if (databus !== 8'h00 || iocs !== 1'b0) begin errors++; $display("FAIL div_done_bus: got bus=%h iocs=%b want 00 0", databus, iocs); end
        req_valid = 2'b00;
        tick();
        checks++; if (databus !== 8'h00 || ack !== 2'b00) begin errors++; $display("FAIL div_after: got bus=%h ack=%b want 00 00", databus, ack); end
        tb_probe_en = 1'b0;
    endtask

    task automatic test_tx_backpressure;
        int acks;
        acks      = 0;
        tbr       = 1'b0;
        rda       = 1'b1;
        req_rw    = 2'b00;
        req_addr  = {2'b00, 2'b00};
        req_wdata = {8'h5A, 8'h00};
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++; if (iocs !== 1'b0 || ack !== 2'b00 || busy !== 1'b1) begin
                errors++; $display("FAIL tx_wait[%0d]: got iocs=%b ack=%b busy=%b want 0 00 1", i, iocs, ack, busy);
            end
            tick();
        end
        checks++; if (iocs !== 1'b0) begin errors++; $display("FAIL tx_wait_last: got iocs=%b want 0", iocs); end
        tbr = 1'b1;
        tick();
        checks++; if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b00 || databus !== 8'h5A) begin
            errors++; $display("FAIL tx_issue: got iocs=%b iorw=%b addr=%b bus=%h want 1 0 00 5a", iocs, iorw, ioaddr, databus);
        end
        tbr = 1'b0;
        rda = 1'b0;
        tick();
        checks++; if (ack !== 2'b10 || err !== 1'b0) begin errors++; $display("FAIL tx_ack: got ack=%b err=%b want 10 0", ack, err); end
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack !== 2'b00) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL tx_ack_once: got %0d extra acks want 0", acks); end
    endtask

    task automatic test_rx_read;
        spart_rdata = 8'hA5;
        tbr         = 1'b1;
        rda         = 1'b0;
        req_rw      = 2'b01;
        req_addr    = {2'b00, 2'b00};
        req_valid   = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (iocs !== 1'b0 || ack !== 2'b00) begin errors++; $display("FAIL rx_wait[%0d]: got iocs=%b ack=%b want 0 00", i, iocs, ack); end
            tick();
        end
        rda = 1'b1;
        tick();
        checks++; if (iocs !== 1'b1 || iorw !== 1'b1 || ioaddr !== 2'b00 || databus !== 8'hA5) begin
            errors++; $display("FAIL rx_issue: got iocs=%b iorw=%b addr=%b bus=%h want 1 1 00 a5", iocs, iorw, ioaddr, databus);
        end
        rda = 1'b0;
        tbr = 1'b0;
        tick();
        checks++; if (ack !== 2'b01 || err !== 1'b0 || rdata !== 8'hA5) begin
            errors++; $display("FAIL rx_ack: got ack=%b err=%b rdata=%h want 01 0 a5", ack, err, rdata);
        end
        req_valid   = 2'b00;
        spart_rdata = 8'h00;
        tick();
        tick();
        checks++; if (rdata !== 8'hA5 || ack !== 2'b00) begin errors++; $display("FAIL rx_hold: got rdata=%h ack=%b want a5 00", rdata, ack); end
    endtask

    task automatic test_reset_in_wait;
        tbr       = 1'b0;
        req_rw    = 2'b00;
        req_addr  = {2'b00, 2'b00};
        req_wdata = {8'h77, 8'h00};
        req_valid = 2'b10;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b want 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b00) begin
            errors++; $display("FAIL rst_async: got busy=%b iocs=%b iorw=%b addr=%b want 0 0 1 00", busy, iocs, iorw, ioaddr);
        end
        checks++; if (rdata !== 8'h00 || ack !== 2'b00 || err !== 1'b0) begin
            errors++; $display("FAIL rst_async_data: got rdata=%h ack=%b err=%b want 00 00 0", rdata, ack, err);
        end
        tbr = 1'b1;
        tick();
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_held: got ack=%b busy=%b want 00 0", ack, busy); end
        tbr = 1'b0;
        rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b1 || iocs !== 1'b0) begin errors++; $display("FAIL rst_regrant: got busy=%b iocs=%b want 1 0", busy, iocs); end
        tbr = 1'b1;
        tick();
        checks++; if (iocs !== 1'b1 || databus !== 8'h77) begin errors++; $display("FAIL rst_issue: got iocs=%b bus=%h want 1 77", iocs, databus); end
        tbr = 1'b0;
        tick();
        checks++; if (ack !== 2'b10 || err !== 1'b0) begin errors++; $display("FAIL rst_ack: got ack=%b err=%b want 10 0", ack, err); end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_timeout;
        spart_rdata2 = 8'h3C;
        rda2         = 1'b0;
        req_rw       = 2'b01;
        req_addr     = {2'b00, 2'b01};
        req_valid2   = 2'b01;
        tick();
        tick();
        checks++; if (iocs2 !== 1'b1 || ioaddr2 !== 2'b01) begin errors++; $display("FAIL to_stat_issue: got iocs=%b addr=%b want 1 01", iocs2, ioaddr2); end
        tick();
        checks++; if (ack2 !== 2'b01 || rdata2 !== 8'h3C) begin errors++; $display("FAIL to_stat_ack: got ack=%b rdata=%h want 01 3c", ack2, rdata2); end
        req_valid2   = 2'b00;
        spart_rdata2 = 8'h00;
        tick();
        req_addr   = {2'b00, 2'b00};
        req_valid2 = 2'b01;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++; if (iocs2 !== 1'b0 || ack2 !== 2'b00 || busy2 !== 1'b1) begin
                errors++; $display("FAIL to_wait[%0d]: got iocs=%b ack=%b busy=%b want 0 00 1", i, iocs2, ack2, busy2);
            end
            tick();
        end
        checks++; if (ack2 !== 2'b01 || err2 !== 1'b1 || iocs2 !== 1'b0) begin
            errors++; $display("FAIL to_ack: got ack=%b err=%b iocs=%b want 01 1 0", ack2, err2, iocs2);
        end
        checks++; if (rdata2 !== 8'h3C) begin errors++; $display("FAIL to_rdata: got %h want 3c", rdata2); end
        req_valid2 = 2'b00;
        tick();
        checks++; if (ack2 !== 2'b00 || err2 !== 1'b0 || busy2 !== 1'b0 || rdata2 !== 8'h3C) begin
            errors++; $display("FAIL to_after: got ack=%b err=%b busy=%b rdata=%h want 00 0 0 3c", ack2, err2, busy2, rdata2);
        end
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = '0;
        req_rw       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        rda          = 1'b0;
        tbr          = 1'b0;
        tb_probe_en  = 1'b0;
        spart_rdata  = 8'h00;
        req_valid2   = '0;
        rda2         = 1'b0;
        spart_rdata2 = 8'h00;

        test_reset();
        test_round_robin();
        test_divisor_write();
        test_tx_backpressure();
        test_rx_read();
        test_reset_in_wait();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spart_bus_arbiter.md
Name: spart_bus_arbiter

Overview:
- Shares one SPART processor bus (iocs/iorw/ioaddr/databus, rda/tbr) between NREQ requesters, e.g. the baud-config loader and the echo/data engine.
- Arbitrates round-robin and holds TX-buffer writes until tbr and RX-buffer reads until rda.
- Issues exactly one single-cycle bus access per transaction and returns an ack, read data and a timeout error.
- Sits between the requester blocks and the SPART; it is the only driver of the SPART bus.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 1024, maximum cycles spent in WAIT before aborting with err; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request; held high until that requester's ack
- req_rw  input  NREQ  1=read, 0=write
- req_addr  input  2*NREQ  ioaddr per requester: [2i+1:2i]
- req_wdata  input  8*NREQ  write data per requester: [8i+7:8i]
- ack  output  NREQ  one-cycle completion pulse, one-hot
- err  output  1  valid with ack; 1 = timeout, no bus access made
- rdata  output  8  read data; valid with ack for reads, holds until the next read completes
- busy  output  1  high from grant through ack
- iocs  output  1  SPART chip select
- iorw  output  1  SPART 1=read, 0=write
- ioaddr  output  2  SPART register address
- rda  input  1  SPART receive data available
- tbr  input  1  SPART transmit buffer ready
- databus  inout  8  SPART data bus

Behaviour:
- Address map: 00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high.
- Reset values: state IDLE; iocs=0; iorw=1; ioaddr=00; databus=Z; ack=0; err=0; rdata=00; busy=0; last_grant=NREQ-1, so requester 0 wins first.
- States and transitions:
  - IDLE: if any req_valid, grant the first asserted requester searching from last_grant+1 with wrap. Register grant index, rw, addr and wdata; update last_grant; go to WAIT.
  - WAIT, write to addr 00: advance to ISSUE when tbr=1.
  - WAIT, read from addr 00: advance to ISSUE when rda=1.
  - WAIT, any other address: advance to ISSUE unconditionally, so WAIT lasts 1 cycle.
  - WAIT, timeout: a wait counter increments each WAIT cycle. At count TIMEOUT-1 with the condition still false, go to DONE with err=1.
  - ISSUE: exactly 1 cycle with iocs=1, iorw=rw, ioaddr=addr. Drive databus=wdata only when rw=0, otherwise Z. For a read, capture databus into rdata at the end of this cycle. Go to DONE.
  - DONE: ack[grant]=1 for 1 cycle; err valid; then IDLE.
- Outside ISSUE, iocs=0, iorw=1 and databus=Z. ioaddr shows the captured addr from WAIT through ISSUE.
- Latency: req_valid sampled in IDLE at cycle 0; WAIT cycle 1; ISSUE cycle 2 at the earliest; ack cycle 3. Peak throughput is one transaction per 4 cycles.
- Request fields are captured at grant. Later changes, or req_valid dropping, do not affect the in-flight transaction, and the transaction always completes.
- rda and tbr are ignored except in WAIT for the matching buffer operation.
- Reset mid-transaction: all outputs return asynchronously to their reset values, databus is released at once, and the transaction is dropped with no ack. A still-asserted request is re-arbitrated after release.
- The wait counter is 16 bits and clears on entry to WAIT.

Decomposition:
- spart_pkg holds:
  - ioaddr constants ADDR_BUF=2'b00, ADDR_STAT=2'b01, ADDR_DBL=2'b10, ADDR_DBH=2'b11
  - the arbiter state typedef {IDLE, WAIT, ISSUE, DONE}
- Sub-module rr_arbiter: combinational; inputs req_valid and last_grant; outputs the one-hot grant and its index.

Test Plan:
- Divisor write: req0 writes addr 10, data 0x45. Cycle 2 shows iocs=1, iorw=0, ioaddr=10, databus=0x45. ack=01 in cycle 3 with err=0. databus is Z in every other cycle.
- Round-robin: both requesters hold valid for 4 transactions from reset. Grants go 0,1,0,1, ack is one-hot each time, and a second 0 is never granted ahead of a waiting 1.
- TX backpressure: req1 writes addr 00, 0x5A, with tbr=0 for 10 cycles, then 1. iocs stays 0 while waiting; ISSUE follows the tbr=1 cycle; ack=10 exactly once.
- RX read: req0 reads addr 00; rda rises after 5 cycles and the SPART drives 0xA5 while iocs=1. rdata=0xA5 with ack=01 and err=0, and rdata holds afterwards.
- Timeout: TIMEOUT=8, read of addr 00 with rda never asserted. After 8 WAIT cycles, ack plus err=1, iocs never asserted, and rdata unchanged.
- Reset in WAIT: rst low during a TX wait. Outputs immediately go to reset values with databus=Z and no ack. After release, the held request is regranted and completes normally.
